modmul_interleaved: RTL and testbench
=====================================

Name: modmul_interleaved

Overview:
- Bit-serial interleaved modular multiplier. Computes p = a*b mod n.
- It is the responder side of the start/ready handshake that the modular-exponentiation controller drives for both its squaring and multiplying units.
- It drops into either unit slot with the same port set: clk, rst, start, ready, a, b, n, p.
- It processes one multiplier bit of b per cycle, MSB first.

Parameters:
W, 2048, operand/modulus width in bits; declared [15:0]; legal range 2..65535.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only while ready=1
ready  output  1  high when idle; p valid and held while high
a  input  W  multiplicand; precondition a < n
b  input  W  multiplier; precondition b < n
n  input  W  modulus
p  output  W  result register, a*b mod n

Behaviour:
- Clock, reset and handshake
  - Single clock domain. Reset is synchronous, active-high, and has priority over everything else.
  - On reset: state=IDLE, ready=1, p=0, accumulator R=0, counter cnt=0. Reset mid-operation aborts the operation immediately; no partial result reaches p.
  - ready is decoded combinationally from the state register (ready = state==IDLE). There is no combinational path from start to ready.
- States: IDLE, CALC, DONE (encodings in package).
- IDLE
  - start=1 and n!=0: latch a, b, n into internal registers; R<=0; cnt<=W-1; go to CALC.
  - start=1 and n==0: p<=0; go to DONE.
  - start=0: hold; p is unchanged.
- CALC, one iteration per cycle on bit bb[cnt]:
  - T = 2*R + (bb[cnt] ? aa : 0). T is held at W+2 bits; T < 3n under the precondition.
  - If T >= nn, subtract nn. If the remainder is still >= nn, subtract nn again. The result is the new R, always < nn.
  - If cnt != 0: cnt<=cnt-1, stay in CALC.
  - If cnt == 0: p<=new R[W-1:0], go to IDLE.
- DONE: one cycle, then go to IDLE. Used only for the n==0 path.
- Latency
  - start sampled at edge t with n!=0: ready=0 for exactly W cycles; ready=1 and p valid at t+W+1.
  - n==0: ready=0 for one cycle; p=0 valid at t+2.
  - ready is therefore always low for at least the cycle after start. This lets the requester detect completion by waiting for ready to rise.
- start while not ready: ignored; has no effect on the operation in flight.
- Back-to-back: start asserted in the first cycle ready returns high is accepted normally.
- Inputs a, b, n may change freely after the start cycle because they are latched.
- p holds its value from completion until the next completion or reset.
- Precondition violations (a>=n or b>=n) give an unspecified value of p. The operation still completes with the same latency; the FSM never hangs.
- Comparisons are unsigned. All subtractions are done at W+2 bits, and the result is truncated to W bits only when written to p.

Decomposition:
- Package modmul_pkg:
  - state encodings IDLE=2'b00, CALC=2'b01, DONE=2'b10;
  - counter width constant CNT_W=16.
- Sub-module modmul_iter_step (combinational):
  - inputs R, aa, nn, bit; output new R;
  - contains the shift/add and the two conditional subtractions;
  - parameterised by W; unit-testable alone.
- The top level holds the FSM, the counter, the operand registers and p.

Test Plan:
1. W=8, a=5, b=7, n=11, start pulse at t -> ready=0 for cycles t+1..t+8; ready=1 at t+9 with p=2; p held afterwards.
2. W=8, a=254, b=254, n=255 -> p=1 at t+9. Also a=0, b=200, n=251 -> p=0; and n=1 -> p=0 after the full W-cycle latency.
3. W=8, n=0, a=3, b=4 -> ready low one cycle only; p=0 and ready=1 at t+2.
4. W=8, start with a=5, b=7, n=11; assert start again at t+3 with a=1, b=1, n=11; change input pins at t+1 -> p=2 at t+9, the second start and the pin changes have no effect. Then start in the first cycle ready=1 with a=10, b=10, n=11 -> p=1 at that start+9.
5. W=8, rst asserted at t+4 mid-operation -> next cycle ready=1 and p=0. A fresh start with a=3, b=9, n=13 -> p=1 after 9 cycles.
6. W=64, 1000 random a, b < random odd n, back-to-back requests -> every p matches the reference model a*b mod n, with latency exactly W+1 per request.

Source files
------------

// File: rtl/modmul_interleaved_pkg.sv
// +--------------------------------------------------------------------------+
// | modmul_pkg : shared state encodings and counter width for modmul_interleaved|
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package modmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/modmul_interleaved_iter_step.sv
// +--------------------------------------------------------------------------+
// | modmul_iter_step : one interleaved step, R' = (2R + bit*aa) mod nn        |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module modmul_iter_step
  import modmul_pkg::*;
#(
  parameter logic [15:0] W = 16'd2048
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] aa_i,
  input  logic [W-1:0] nn_i,
  input  logic         bit_i,
  output logic [W-1:0] r_o
);

  logic [W+1:0] w_n;
  logic [W+1:0] w_t;
  logic [W+1:0] w_s1;
  logic [W+1:0] w_s2;
  logic         w_unused_hi;

  // T < 3*nn when R, aa < nn, so two conditional subtractions suffice.
  always_comb begin
    w_n  = {2'b00, nn_i};
    w_t  = {1'b0, r_i, 1'b0} + (bit_i ? {2'b00, aa_i} : '0);
    w_s1 = (w_t  >= w_n) ? (w_t  - w_n) : w_t;
    w_s2 = (w_s1 >= w_n) ? (w_s1 - w_n) : w_s1;
  end

  assign r_o         = w_s2[W-1:0];
  assign w_unused_hi = ^w_s2[W+1:W];

endmodule

`default_nettype wire

// File: rtl/modmul_interleaved.sv
// +--------------------------------------------------------------------------+
// | modmul_interleaved : bit-serial interleaved modular multiplier p=a*b mod n|
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module modmul_interleaved
  import modmul_pkg::*;
#(
  parameter logic [15:0] W = 16'd2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] p
);

  state_e             state_q, state_d;
  logic [W-1:0]       aa_q, aa_d;
  logic [W-1:0]       bb_q, bb_d;
  logic [W-1:0]       nn_q, nn_d;
  logic [W-1:0]       r_q, r_d;
  logic [W-1:0]       p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       w_r_new;

  // bb is shifted left each step, so its MSB is always the current bit.
  modmul_iter_step #(
    .W (W)
  ) u_step (
    .r_i   (r_q),
    .aa_i  (aa_q),
    .nn_i  (nn_q),
    .bit_i (bb_q[W-1]),
    .r_o   (w_r_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aa_q    <= '0;
      bb_q    <= '0;
      nn_q    <= '0;
      r_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aa_q    <= aa_d;
      bb_q    <= bb_d;
      nn_q    <= nn_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    aa_d    = aa_q;
    bb_d    = bb_q;
    nn_d    = nn_q;
    r_d     = r_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n != '0) begin
            aa_d    = a;
            bb_d    = b;
            nn_d    = n;
            r_d     = '0;
            cnt_d   = W - 16'd1;
            state_d = CALC;
          end else begin
            p_d     = '0;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        r_d  = w_r_new;
        bb_d = bb_q << 1;
        if (cnt_q == '0) begin
          p_d     = w_r_new;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign p     = p_q;

endmodule

`default_nettype wire

// File: tb/tb_modmul_interleaved.sv
// +--------------------------------------------------------------------------+
// | tb_modmul_interleaved : scoreboard bench for W=8 and W=64 instances      |
// | Revision              : 1.0                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_modmul_interleaved;

  typedef struct {
    logic [63:0] p;
    int          t0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic        start64 = 1'b0;
  logic        ready8, ready64;
  logic [7:0]  a8 = '0, b8 = '0, n8 = '0, p8;
  logic [63:0] a64 = '0, b64 = '0, n64 = '0, p64;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q64[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modmul_interleaved #(.W(16'd8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .ready (ready8),
    .a     (a8),
    .b     (b8),
    .n     (n8),
    .p     (p8)
  );

  modmul_interleaved #(.W(16'd64)) u_dut64 (
    .clk   (clk),
    .rst   (rst),
    .start (start64),
    .ready (ready64),
    .a     (a64),
    .b     (b64),
    .n     (n64),
    .p     (p64)
  );

  function automatic logic [63:0] ref_mod(logic [63:0] a, logic [63:0] b, logic [63:0] n);
    logic [127:0] pr;
    logic [127:0] r;
    if (n == 64'd0) return 64'd0;
    pr = {64'd0, a} * {64'd0, b};
    r  = pr % {64'd0, n};
    return r[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Monitor for the W=8 instance
  initial begin
    logic prev;
    exp_t e;
    logic [63:0] last;
    prev = 1'b1;
    last = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        q8.delete();
        last = '0;
        chk("rst_ready8", {63'd0, ready8}, 64'd1);
        chk("rst_p8", {56'd0, p8}, 64'd0);
        prev = 1'b1;
      end else begin
        if (!prev && ready8) begin
          if (q8.size() == 0) begin
            fail_now("unexpected_done8");
          end else begin
            e = q8.pop_front();
            chk("p8", {56'd0, p8}, e.p);
            chk("lat8", 64'(cyc - e.t0), 64'(e.lat));
            last = e.p;
          end
        end else if (ready8) begin
          chk("hold8", {56'd0, p8}, last);
        end
        prev = ready8;
      end
    end
  end

  // Monitor for the W=64 instance
  initial begin
    logic prev;
    exp_t e;
    logic [63:0] last;
    prev = 1'b1;
    last = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        q64.delete();
        last = '0;
        chk("rst_ready64", {63'd0, ready64}, 64'd1);
        chk("rst_p64", p64, 64'd0);
        prev = 1'b1;
      end else begin
        if (!prev && ready64) begin
          if (q64.size() == 0) begin
            fail_now("unexpected_done64");
          end else begin
            e = q64.pop_front();
            chk("p64", p64, e.p);
            chk("lat64", 64'(cyc - e.t0), 64'(e.lat));
            last = e.p;
          end
        end else if (ready64) begin
          chk("hold64", p64, last);
        end
        prev = ready64;
      end
    end
  end

  task automatic wait_ready8();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready8 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready8) fail_now("wait_ready8");
  endtask

  task automatic wait_ready64();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready64 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready64) fail_now("wait_ready64");
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    wait_ready8();
    a8 = a; b8 = b; n8 = n; start8 = 1'b1;
    q8.push_back('{ref_mod({56'd0, a}, {56'd0, b}, {56'd0, n}), cyc, (n == 8'd0) ? 2 : 9});
    @(negedge clk);
    start8 = 1'b0;
    chk("busy8", {63'd0, ready8}, 64'd0);
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] n);
    wait_ready64();
    a64 = a; b64 = b; n64 = n; start64 = 1'b1;
    q64.push_back('{ref_mod(a, b, n), cyc, (n == 64'd0) ? 2 : 65});
    @(negedge clk);
    start64 = 1'b0;
  endtask

  initial begin
    logic [63:0] ra, rb, rn;
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed W=8 cases, including n==1 and n==0 boundaries
    issue8(8'd5, 8'd7, 8'd11);
    issue8(8'd254, 8'd254, 8'd255);
    issue8(8'd0, 8'd200, 8'd251);
    issue8(8'd3, 8'd4, 8'd1);
    issue8(8'd3, 8'd4, 8'd0);

    // Pins change after start and a start arrives mid-operation
    wait_ready8();
    a8 = 8'd5; b8 = 8'd7; n8 = 8'd11; start8 = 1'b1;
    q8.push_back('{64'd2, cyc, 9});
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd99; b8 = 8'd88; n8 = 8'd77;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; n8 = 8'd11;
    @(negedge clk);
    start8 = 1'b0;
    issue8(8'd10, 8'd10, 8'd11);

    // Reset mid-operation, then a fresh request
    issue8(8'd3, 8'd5, 8'd13);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue8(8'd3, 8'd9, 8'd13);

    // W=64 directed then randomized back-to-back traffic
    issue64(64'd5, 64'd7, 64'd11);
    issue64(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
    issue64(64'd3, 64'd4, 64'd0);
    for (int i = 0; i < 1000; i++) begin
      rn = {$urandom(), $urandom()} | 64'd1;
      if (rn == 64'd1) rn = 64'd3;
      ra = {$urandom(), $urandom()} % rn;
      rb = {$urandom(), $urandom()} % rn;
      issue64(ra, rb, rn);
    end

    guard = 0;
    while ((q8.size() != 0 || q64.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (q8.size() != 0 || q64.size() != 0) fail_now("drain");
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
